// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : store_buffer
// Description : Posted-write FIFO between the core load/store port and data
//               memory, with youngest-entry store-to-load forwarding and flush.
// Revision    : 1.0 - initial release
// ============================================================================
module store_buffer #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    cpu_mem_write,
    input  logic                    cpu_mem_read,
    input  logic [ADDR_WIDTH-1:0]   cpu_address,
    input  logic [DATA_WIDTH-1:0]   cpu_write_data,
    output logic [DATA_WIDTH-1:0]   cpu_read_data,
    output logic                    cpu_stall,
    input  logic                    flush_req,
    output logic                    flush_done,
    output logic                    dm_mem_write,
    output logic                    dm_mem_read,
    output logic [ADDR_WIDTH-1:0]   dm_address,
    output logic [DATA_WIDTH-1:0]   dm_write_data,
    input  logic [DATA_WIDTH-1:0]   dm_read_data,
    output logic [$clog2(DEPTH):0]  buffer_count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [ADDR_WIDTH-1:0]   r_addr_q [DEPTH];
    logic [DATA_WIDTH-1:0]   r_data_q [DEPTH];
    logic [c_PTR_W-1:0]      r_head;
    logic [c_PTR_W-1:0]      r_tail;
    logic [c_CNT_W-1:0]      r_count;

    logic                    w_store;
    logic                    w_load;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_hit;
    logic [DATA_WIDTH-1:0]   w_hit_data;
    logic [c_PTR_W-1:0]      w_idx;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_issue_read;

    // A simultaneous read+write request is handled as a store.
    assign w_store      = cpu_mem_write;
    assign w_load       = cpu_mem_read & ~cpu_mem_write;
    assign w_full       = (r_count == c_CNT_W'(DEPTH));
    assign w_empty      = (r_count == '0);
    assign buffer_count = r_count;

    // Walk oldest to youngest so the youngest match wins.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_data = '0;
        w_idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_head + c_PTR_W'(i);
            if ((c_CNT_W'(i) < r_count) && (r_addr_q[w_idx] == cpu_address)) begin
                w_hit      = 1'b1;
                w_hit_data = r_data_q[w_idx];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_push        = 1'b0;
        w_pop         = 1'b0;
        w_issue_read  = 1'b0;
        cpu_stall     = 1'b0;
        cpu_read_data = '0;
        case (r_state)
            S_IDLE: begin
                if (w_store) begin
                    // A full buffer still drains while the core is held.
                    cpu_stall = w_full;
                    w_pop     = w_full;
                    w_push    = ~w_full;
                end else if (w_load) begin
                    if (w_hit) begin
                        cpu_read_data = w_hit_data;
                    end else begin
                        cpu_stall    = 1'b1;
                        w_issue_read = 1'b1;
                        w_next       = S_LOAD;
                    end
                end else begin
                    w_pop = ~w_empty;
                end
                if (flush_req && !w_issue_read) begin
                    w_next = S_FLUSH;
                end
            end
            S_LOAD: begin
                cpu_read_data = dm_read_data;
                w_next        = S_IDLE;
            end
            S_FLUSH: begin
                cpu_stall = cpu_mem_write | cpu_mem_read;
                w_pop     = ~w_empty;
                if (w_empty) begin
                    w_next = S_DONE;
                end
            end
            default: begin
                cpu_stall = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_addr_q[r_tail] <= cpu_address;
            r_data_q[r_tail] <= cpu_write_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            dm_mem_write  <= 1'b0;
            dm_mem_read   <= 1'b0;
            dm_address    <= '0;
            dm_write_data <= '0;
            flush_done    <= 1'b0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            r_count     <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
            dm_mem_read <= w_issue_read;
            flush_done  <= (w_next == S_DONE);
            if (w_issue_read) begin
                dm_mem_write <= 1'b0;
                dm_address   <= cpu_address;
            end else if (w_pop) begin
                dm_mem_write  <= 1'b1;
                dm_address    <= r_addr_q[r_head];
                dm_write_data <= r_data_q[r_head];
            end else begin
                dm_mem_write <= 1'b0;
                if (w_next == S_DONE) begin
                    dm_address    <= '0;
                    dm_write_data <= '0;
                end
            end
        end
    end

endmodule
`default_nettype wire
